// File: rtl/mem_port_arbiter_if.sv
// Bundle for the two core-side requesters and the single memory port of mem_port_arbiter.
// slave = arbiter side; master = requesters plus the memory they share.
interface mem_port_arbiter_if #(
    parameter int MEM_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req0_valid, req0_we, req0_ready, req0_done, req0_err;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [MEM_WIDTH-1:0]  req0_wdata, req0_rdata;
    logic                  req1_valid, req1_we, req1_ready, req1_done, req1_err;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [MEM_WIDTH-1:0]  req1_wdata, req1_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read_en, mem_write_en;
    logic [MEM_WIDTH-1:0]  mem_write_val, mem_read_val;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_read_val,
        output req0_ready, req0_done, req0_rdata, req0_err,
        output req1_ready, req1_done, req1_rdata, req1_err,
        output mem_addr, mem_read_en, mem_write_en, mem_write_val
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_read_val,
        input  req0_ready, req0_done, req0_rdata, req0_err,
        input  req1_ready, req1_done, req1_rdata, req1_err,
        input  mem_addr, mem_read_en, mem_write_en, mem_write_val
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the single data-memory port, 3 cycles per access.
// Optional MEM_ARB_RANGE_CHECK_EN: out-of-range addresses skip memory and complete with err=1.
module mem_port_arbiter #(
    parameter int MEM_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 256
) (
    input logic clk,
    input logic rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, state_nxt;
    logic [1:0]            valid, ready, done;
    logic                  last_grant, grant, grant_nxt;
    logic                  lat_we, mem_ok;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [MEM_WIDTH-1:0]  lat_wdata, rdata;

    assign valid = {bus.req1_valid, bus.req0_valid};

    // On contention the requester that did not win last time goes first.
    assign grant_nxt = (valid == 2'b11) ? ~last_grant : valid[1];

`ifdef MEM_ARB_RANGE_CHECK_EN
    assign mem_ok      = lat_addr < ADDR_WIDTH'(MEM_SIZE);
    assign bus.req0_err = done[0] & ~mem_ok;
    assign bus.req1_err = done[1] & ~mem_ok;
`else
    assign mem_ok      = 1'b1;
    assign bus.req0_err = 1'b0;
    assign bus.req1_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (state == IDLE && |valid) begin
            grant      <= grant_nxt;
            last_grant <= grant_nxt;
            lat_we     <= grant_nxt ? bus.req1_we    : bus.req0_we;
            lat_addr   <= grant_nxt ? bus.req1_addr  : bus.req0_addr;
            lat_wdata  <= grant_nxt ? bus.req1_wdata : bus.req0_wdata;
        end
    end

    // All outputs decode from state, so an async reset clears them immediately.
    always_comb begin
        state_nxt         = state;
        ready             = '0;
        done              = '0;
        rdata             = '0;
        bus.mem_addr      = '0;
        bus.mem_write_val = '0;
        bus.mem_read_en   = 1'b0;
        bus.mem_write_en  = 1'b0;
        case (state)
            IDLE: if (|valid) state_nxt = ACCESS;
            ACCESS: begin
                state_nxt         = RESP;
                ready[grant]      = 1'b1;
                bus.mem_addr      = lat_addr;
                bus.mem_write_val = lat_wdata;
                bus.mem_read_en   = ~lat_we & mem_ok;
                bus.mem_write_en  = lat_we & mem_ok;
            end
            RESP: begin
                state_nxt   = IDLE;
                done[grant] = 1'b1;
                if (!lat_we && mem_ok) rdata = bus.mem_read_val;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.req0_done  = done[0];
    assign bus.req1_done  = done[1];
    assign bus.req0_rdata = done[0] ? rdata : '0;
    assign bus.req1_rdata = done[1] ? rdata : '0;
endmodule
